work_loader: RTL and testbench

WORK_LOADER -- requirements
Module: work_loader

---
 rtl/work_loader.sv | 195 +++++++++++++++++++
 tb/tb_work_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/work_loader.sv
// Host-link frame loader: hunts for SYNC_BYTE, gathers 44 payload bytes into
// eleven big-endian words and plays them to the miner on eleven consecutive cycles.
// Optional trailing XOR checksum byte is enabled by defining WORK_LOADER_CHECKSUM_EN.
module work_loader #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        ready,
  output logic [31:0] serial_in,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
`ifdef WORK_LOADER_CHECKSUM_EN
    CHK  = 2'd2,
`endif
    SEND = 2'd3
  } state_t;

  localparam logic [5:0]  LAST_BYTE = 6'd43;
  localparam logic [3:0]  NUM_WORDS = 4'd11;
  localparam logic [23:0] GAP_MAX   = 24'hFFFFFF;

  state_t      state_r;
  logic [5:0]  byte_cnt_r;
  logic [23:0] gap_r;
  logic [3:0]  send_idx_r;
  logic [31:0] word_buf_r [0:10];
  logic        ready_r;
  logic [31:0] serial_in_r;
  logic        frame_err_r;
  logic        overrun_r;

  logic        byte_accept_s;
  logic [23:0] gap_next_s;
  logic        gap_expired_s;
  logic        last_byte_s;

`ifdef WORK_LOADER_CHECKSUM_EN
  logic [7:0]  xor_r;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction
`endif

  // Payload acceptance, saturating gap increment and inter-byte timeout detection
  always_comb begin
    byte_accept_s = rx_valid && (state_r == RECV);
    last_byte_s   = (byte_cnt_r == LAST_BYTE);
    if (gap_r == GAP_MAX) begin
      gap_next_s = gap_r;
    end else begin
      gap_next_s = gap_r + 24'd1;
    end
    gap_expired_s = (gap_next_s >= TIMEOUT_CYCLES);
  end

  // Payload buffer; left unreset because nothing reads it before it is rewritten
  always_ff @(posedge clk) begin
    if (byte_accept_s) begin
      case (byte_cnt_r[1:0])
        2'd0:    word_buf_r[byte_cnt_r[5:2]][31:24] <= rx_data;
        2'd1:    word_buf_r[byte_cnt_r[5:2]][23:16] <= rx_data;
        2'd2:    word_buf_r[byte_cnt_r[5:2]][15:8]  <= rx_data;
        default: word_buf_r[byte_cnt_r[5:2]][7:0]   <= rx_data;
      endcase
    end
  end

  // Frame FSM with registered outputs; SEND entry loads word0 so ready rises the cycle after the final byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      byte_cnt_r  <= 6'd0;
      gap_r       <= 24'd0;
      send_idx_r  <= 4'd0;
      ready_r     <= 1'b0;
      serial_in_r <= 32'h0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef WORK_LOADER_CHECKSUM_EN
      xor_r       <= 8'h00;
`endif
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          ready_r     <= 1'b0;
          serial_in_r <= 32'h0;
          gap_r       <= 24'd0;
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_r    <= RECV;
            byte_cnt_r <= 6'd0;
`ifdef WORK_LOADER_CHECKSUM_EN
            xor_r      <= 8'h00;
`endif
          end else begin
            state_r <= IDLE;
          end
        end

        RECV: begin
          if (rx_valid) begin
            gap_r      <= 24'd0;
            byte_cnt_r <= byte_cnt_r + 6'd1;
`ifdef WORK_LOADER_CHECKSUM_EN
            xor_r      <= xor_fold(xor_r, rx_data);
            if (last_byte_s) begin
              state_r <= CHK;
            end else begin
              state_r <= RECV;
            end
`else
            if (last_byte_s) begin
              state_r     <= SEND;
              ready_r     <= 1'b1;
              serial_in_r <= word_buf_r[0];
              send_idx_r  <= 4'd1;
            end else begin
              state_r <= RECV;
            end
`endif
          end else if (gap_expired_s) begin
            frame_err_r <= 1'b1;
            gap_r       <= 24'd0;
            state_r     <= IDLE;
          end else begin
            gap_r <= gap_next_s;
          end
        end

`ifdef WORK_LOADER_CHECKSUM_EN
        CHK: begin
          if (rx_valid) begin
            gap_r <= 24'd0;
            if (rx_data == xor_r) begin
              state_r     <= SEND;
              ready_r     <= 1'b1;
              serial_in_r <= word_buf_r[0];
              send_idx_r  <= 4'd1;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= IDLE;
            end
          end else if (gap_expired_s) begin
            frame_err_r <= 1'b1;
            gap_r       <= 24'd0;
            state_r     <= IDLE;
          end else begin
            gap_r <= gap_next_s;
          end
        end
`endif

        SEND: begin
          gap_r     <= 24'd0;
          // bytes arriving while words stream out are dropped, never parsed
          overrun_r <= rx_valid;
          if (send_idx_r == NUM_WORDS) begin
            ready_r     <= 1'b0;
            serial_in_r <= 32'h0;
            send_idx_r  <= 4'd0;
            state_r     <= IDLE;
          end else begin
            serial_in_r <= word_buf_r[send_idx_r];
            send_idx_r  <= send_idx_r + 4'd1;
          end
        end

        default: begin
          state_r     <= IDLE;
          ready_r     <= 1'b0;
          serial_in_r <= 32'h0;
          gap_r       <= 24'd0;
          send_idx_r  <= 4'd0;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign serial_in = serial_in_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_work_loader.sv
// Scoreboard bench for work_loader: frame-level reference builds expected words
// and pulse times; a negedge monitor pops and compares whatever the DUT presents.
module tb_work_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 16;
`ifdef WORK_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        ready;
  logic [31:0] serial_in;
  logic        frame_err;
  logic        overrun;

  work_loader #(.TIMEOUT_CYCLES(24'd16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ready(ready), .serial_in(serial_in), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct { int e; logic [31:0] w; } exp_word_t;
  exp_word_t wq[$];
  int        ferr_q[$];
  int        ovr_q[$];
  int        errors = 0;
  int        checks = 0;
  bit        mon_en = 1'b0;
  logic [7:0] payload [44];
  exp_word_t cur;
  int        ce;

  // Monitor: every output cycle is matched against the scoreboard queues
  always @(negedge clk) begin
    if (mon_en) begin
      if (wq.size() > 0 && wq[0].e < edge_n) begin
        checks++; errors++;
        $display("FAIL word_missing: at edge %0d ready=0, required %h at edge %0d", edge_n, wq[0].w, wq[0].e);
        wq.delete(0);
      end
      if (ready) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: edge %0d serial_in=%h, required ready=0", edge_n, serial_in);
        end else begin
          cur = wq.pop_front();
          if (cur.e != edge_n || cur.w !== serial_in) begin
            errors++;
            $display("FAIL word: got %h at edge %0d, required %h at edge %0d", serial_in, edge_n, cur.w, cur.e);
          end
        end
      end else begin
        checks++;
        if (serial_in !== 32'h0) begin
          errors++;
          $display("FAIL idle_serial: serial_in=%h while ready=0, required 00000000", serial_in);
        end
      end
      if (ferr_q.size() > 0 && ferr_q[0] < edge_n) begin
        checks++; errors++;
        $display("FAIL frame_err_missing: edge %0d, required pulse at edge %0d", edge_n, ferr_q[0]);
        ferr_q.delete(0);
      end
      if (frame_err) begin
        checks++;
        ce = (ferr_q.size() > 0) ? ferr_q.pop_front() : -1;
        if (ce != edge_n) begin
          errors++;
          $display("FAIL frame_err: pulse at edge %0d, required edge %0d", edge_n, ce);
        end
      end
      if (ovr_q.size() > 0 && ovr_q[0] < edge_n) begin
        checks++; errors++;
        $display("FAIL overrun_missing: edge %0d, required pulse at edge %0d", edge_n, ovr_q[0]);
        ovr_q.delete(0);
      end
      if (overrun) begin
        checks++;
        ce = (ovr_q.size() > 0) ? ovr_q.pop_front() : -1;
        if (ce != edge_n) begin
          errors++;
          $display("FAIL overrun: pulse at edge %0d, required edge %0d", edge_n, ce);
        end
      end
      if (frame_err && overrun) begin
        checks++; errors++;
        $display("FAIL pulse_overlap: frame_err=1 overrun=1 at edge %0d, required not both", edge_n);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte presented for one cycle; e returns the edge that sampled it
  task automatic put(input logic [7:0] b, output int e);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    e        = edge_n;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  function automatic logic [31:0] word_of(input int i);
    return (32'(payload[4*i]) << 24) | (32'(payload[4*i+1]) << 16) |
           (32'(payload[4*i+2]) << 8) | 32'(payload[4*i+3]);
  endfunction

  function automatic logic [7:0] rand_garbage();
    logic [7:0] g;
    g = 8'($urandom_range(0, 255));
    return (g == SYNC) ? 8'h5B : g;
  endfunction

  task automatic load_payload(input bit directed, input int gap_lo, input int gap_hi,
                              output logic [7:0] ck, output int e);
    ck = 8'h00;
    put(SYNC, e);
    for (int i = 0; i < 44; i++) begin
      payload[i] = directed ? 8'(i) : 8'($urandom_range(0, 255));
      ck ^= payload[i];
      idle(int'($urandom_range(gap_hi, gap_lo)));
      put(payload[i], e);
    end
  endtask

  task automatic send_frame(input bit directed, input int gap_lo, input int gap_hi,
                            input bit bad_ck, input int ovr_at, input logic [7:0] ovr_byte);
    int e, e2;
    logic [7:0] ck;
    exp_word_t t;
    load_payload(directed, gap_lo, gap_hi, ck, e);
    if (CK_EN) begin
      idle(int'($urandom_range(gap_hi, gap_lo)));
      put(bad_ck ? (ck ^ 8'h5A) : ck, e);
    end
    if (CK_EN && bad_ck) begin
      ferr_q.push_back(e);
      idle(4);
    end else begin
      for (int i = 0; i < 11; i++) begin
        t.e = e + i;
        t.w = word_of(i);
        wq.push_back(t);
      end
      if (ovr_at >= 0) begin
        idle(ovr_at);
        put(ovr_byte, e2);
        ovr_q.push_back(e2);
      end
      idle(12);
    end
  endtask

  task automatic send_trunc(input int n, input int gap_lo, input int gap_hi);
    int e;
    put(SYNC, e);
    for (int i = 0; i < n; i++) begin
      idle(int'($urandom_range(gap_hi, gap_lo)));
      put(8'($urandom_range(0, 255)), e);
    end
    ferr_q.push_back(e + TO);
    idle(TO + 4);
  endtask

  task automatic reset_during_send();
    int e;
    logic [7:0] ck;
    exp_word_t t;
    load_payload(1'b0, 0, 1, ck, e);
    if (CK_EN) put(ck, e);
    for (int i = 0; i < 5; i++) begin
      t.e = e + i;
      t.w = word_of(i);
      wq.push_back(t);
    end
    idle(4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_send_ready", 32'(ready), 32'h0);
    check("reset_send_serial", serial_in, 32'h0);
    idle(15);
  endtask

  initial begin
    int e;
    int kind;
    rst_n = 1'b0;
    idle(3);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_serial", serial_in, 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    send_frame(1'b1, 0, 0, 1'b0, -1, 8'h00);
    if (CK_EN) begin
      send_frame(1'b1, 0, 0, 1'b1, -1, 8'h00);
      send_frame(1'b1, 0, 0, 1'b0, -1, 8'h00);
    end
    put(8'h11, e);
    put(8'h22, e);
    send_frame(1'b0, 0, 1, 1'b0, -1, 8'h00);
    send_trunc(10, 0, 0);
    send_frame(1'b0, 0, 0, 1'b0, -1, 8'h00);
    send_frame(1'b1, 0, 0, 1'b0, 2, SYNC);
    put(8'h3C, e);
    send_frame(1'b0, 0, 0, 1'b0, -1, 8'h00);
    send_frame(1'b0, 15, 15, 1'b0, -1, 8'h00);
    reset_during_send();
    send_frame(1'b0, 0, 2, 1'b0, -1, 8'h00);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) begin
        put(rand_garbage(), e);
        idle(int'($urandom_range(0, 2)));
      end
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: send_frame(1'b0, 0, 3, 1'b0, -1, 8'h00);
        1: send_frame(1'b0, 0, 2, 1'b1, -1, 8'h00);
        2: send_trunc(int'($urandom_range(CK_EN ? 44 : 43, 0)), 0, 3);
        default: send_frame(1'b0, 0, 1, 1'b0, int'($urandom_range(0, 10)), 8'($urandom_range(0, 255)));
      endcase
    end

    idle(20);
    check("left_words", 32'(wq.size()), 32'h0);
    check("left_frame_err", 32'(ferr_q.size()), 32'h0);
    check("left_overrun", 32'(ovr_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
